// File: rtl/vdp_vram_host_port_pkg.sv
// Shared VDP definitions for the host VRAM write port: FIFO depth, register
// reset values and the layout of one pending write entry.
package vdp_vram_host_port_pkg;

  localparam int          VDP_FIFO_DEPTH = 8;
  localparam logic [14:0] VDP_ADDR_RESET = 15'h0000;
  localparam logic [7:0]  VDP_INCR_RESET = 8'h01;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } vdp_entry_t;

  localparam int VDP_ENTRY_W = $bits(vdp_entry_t);

  // Word address bit 0 picks the odd (10) or even (01) RAM port.
  function automatic logic [1:0] vdp_port_mask(input logic addr_lsb);
    logic [1:0] mask_v;
    if (addr_lsb) begin
      mask_v = 2'b10;
    end else begin
      mask_v = 2'b01;
    end
    return mask_v;
  endfunction

endpackage

// File: rtl/vdp_vram_host_port_sync_fifo.sv
// Generic single-clock show-ahead FIFO; the head entry is read straight
// from storage, and a push into a full FIFO is accepted only alongside a pop.
module vdp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_s     = pop && !empty;
  assign push_s    = push && (!full || pop_s);
  assign head_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/vdp_vram_host_port.sv
// Host-side VRAM write port: auto-incrementing word address, write FIFO
// towards the VRAM arbiter and a sticky overflow flag for dropped pushes.
module vdp_vram_host_port
  import vdp_vram_host_port_pkg::*;
#(
  parameter int DEPTH = VDP_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_address_write_en,
  input  logic [14:0] host_address,
  input  logic        host_increment_write_en,
  input  logic [7:0]  host_increment,
  input  logic        host_data_write_en,
  input  logic [15:0] host_data,
  input  logic        overflow_clear,
  output logic        host_ready,
  output logic        fifo_empty,
  output logic        overflow,
  output logic [13:0] vram_write_address_16b,
  output logic [15:0] vram_write_data_16b,
  output logic [1:0]  vram_port_write_en_mask,
  input  logic        vram_written
);

  logic [14:0] addr_r;
  logic [7:0]  incr_r;
  logic        overflow_r;
  logic [14:0] used_addr_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_ok_s;
  logic        push_drop_s;
  vdp_entry_t  push_entry_s;
  vdp_entry_t  head_entry_s;

  assign pop_s       = vram_written && !empty_s;
  assign push_ok_s   = host_data_write_en && (!full_s || pop_s);
  assign push_drop_s = host_data_write_en && !push_ok_s;

  // A same-cycle address write overrides the register for this push.
  always_comb begin
    used_addr_s       = addr_r;
    push_entry_s      = '{addr: 14'h0000, data: 16'h0000, mask: 2'b00};
    if (host_address_write_en) begin
      used_addr_s = host_address;
    end else begin
      used_addr_s = addr_r;
    end
    push_entry_s.addr = used_addr_s[14:1];
    push_entry_s.data = host_data;
    push_entry_s.mask = vdp_port_mask(used_addr_s[0]);
  end

  // Address, increment and overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r     <= VDP_ADDR_RESET;
      incr_r     <= VDP_INCR_RESET;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        addr_r <= used_addr_s + {7'b0000000, incr_r};
      end else if (host_address_write_en) begin
        addr_r <= host_address;
      end else begin
        addr_r <= addr_r;
      end
      if (host_increment_write_en) begin
        incr_r <= host_increment;
      end
      // A drop wins over a coincident clear so no dropped word goes unreported.
      if (push_drop_s) begin
        overflow_r <= 1'b1;
      end else if (overflow_clear) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  vdp_sync_fifo #(
    .WIDTH (VDP_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_ok_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign host_ready              = !full_s;
  assign fifo_empty              = empty_s;
  assign overflow                = overflow_r;
  assign vram_write_address_16b  = head_entry_s.addr;
  assign vram_write_data_16b     = head_entry_s.data;
  assign vram_port_write_en_mask = empty_s ? 2'b00 : head_entry_s.mask;

endmodule

// File: doc/vdp_vram_host_port.md
VDP_VRAM_HOST_PORT -- requirements
Module: vdp_vram_host_port

Interface
REQ-001 SHALL have parameter: DEPTH, 8, write FIFO entries (power of two, 2..32).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: host_address_write_en  in  1  load the word address register.
REQ-005 SHALL have port: host_address  in  15  word address; bit 0 selects odd/even RAM, bits [14:1] give the 16-bit RAM address.
REQ-006 SHALL have port: host_increment_write_en  in  1  load the increment register.
REQ-007 SHALL have port: host_increment  in  8  auto-increment step in words.
REQ-008 SHALL have port: host_data_write_en  in  1  push one data word.
REQ-009 SHALL have port: host_data  in  16  data word.
REQ-010 SHALL have port: overflow_clear  in  1  clear the sticky overflow flag.
REQ-011 SHALL have port: host_ready  out  1  FIFO not full (combinational).
REQ-012 SHALL have port: fifo_empty  out  1  no pending writes.
REQ-013 SHALL have port: overflow  out  1  sticky flag: a push was dropped.
REQ-014 SHALL have port: vram_write_address_16b  out  14  head-entry RAM address.
REQ-015 SHALL have port: vram_write_data_16b  out  16  head-entry data.
REQ-016 SHALL have port: vram_port_write_en_mask  out  2  head-entry port mask, 2'b00 when empty.
REQ-017 SHALL have port: vram_written  in  1  arbiter consumed the head this cycle (one-cycle pulse, at most every 8 cycles).

Function
REQ-018 Entry SHALL store {address[14:1], data, mask}; mask = 2'b01 if address bit 0 = 0, else 2'b10.
REQ-019 Push SHALL be accepted when host_data_write_en && (!full || vram_written && !empty).
REQ-020 Accepted push SHALL use the address register value, or host_address if host_address_write_en is asserted in the same cycle.
REQ-021 After an accepted push, address SHALL become used_address + increment, modulo 2^15.
REQ-022 host_increment_write_en SHALL take effect for the next push, not for a push in the same cycle.
REQ-023 Rejected push (full, no pop) SHALL leave FIFO and address unchanged and set overflow.
REQ-024 If overflow_clear and a rejected push coincide, overflow SHALL end the cycle set.
REQ-025 Head outputs SHALL be combinational from storage; a push into an empty FIFO SHALL be visible on the next cycle.
REQ-026 vram_written with FIFO non-empty SHALL pop the head on that edge; with FIFO empty it SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL keep the count unchanged and preserve FIFO order.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-029 fifo_empty SHALL be count==0; host_ready SHALL be count!=DEPTH.

Reset
REQ-030 On reset_n low, SHALL immediately clear: pointers and count to 0, address to 0, increment to 1, overflow to 0.
REQ-031 During and after reset, outputs SHALL read fifo_empty=1, host_ready=1, mask=2'b00.
REQ-032 Entries pending at reset SHALL be discarded; storage contents need no reset.

Structure
REQ-033 DEPTH default, the address/increment reset values and the entry field layout SHALL live in a shared VDP header/package.
REQ-034 Storage SHALL be one generic sub-module, vdp_sync_fifo (push/pop/full/empty, show-ahead head).
REQ-035 Address/increment registers and mask encoding SHALL live in the top module.

Verification
REQ-036 Set address 0x0005, increment 2, push 0xAAAA, 0xBBBB -> heads {addr 0x0002, mask 10, 0xAAAA} then {addr 0x0003, mask 10, 0xBBBB}; address register = 0x0009.
REQ-037 Push 9 words with DEPTH=8 and no pops -> 9th word dropped, overflow=1, host_ready=0, address advanced by 8 increments only.
REQ-038 FIFO full; push and vram_written in the same cycle -> both take effect, count stays 8, order preserved, overflow stays 0.
REQ-039 Address 0x7FFF, increment 1, two pushes -> second entry uses address 0x0000, mask 01.
REQ-040 vram_written pulses while empty -> no state change, mask stays 2'b00.
REQ-041 Assert reset_n low mid-burst with 3 entries pending -> asynchronous clear; fifo_empty=1 and increment=1 before the next clock edge.
